// File: rtl/free_list_mp.sv
// free_list_mp: multi-lane circular free list of physical tags with all-or-nothing allocation.
// Define FREE_LIST_CKPT_EN to add a single head-pointer checkpoint (save/restore).
module free_list_mp #(
    parameter int TAG_W    = 6,
    parameter int NUM_TAGS = 32,
    parameter int TAG_BASE = 32,
    parameter int ALLOC_W  = 2,
    parameter int FREE_W   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ALLOC_W-1:0]         alloc_req,
    output logic                       alloc_gnt,
    output logic [ALLOC_W*TAG_W-1:0]   alloc_tag,
    input  logic [FREE_W-1:0]          free_vld,
    input  logic [FREE_W*TAG_W-1:0]    free_tag,
    input  logic                       ckpt_save,
    input  logic                       ckpt_restore,
    output logic [$clog2(NUM_TAGS):0]  count,
    output logic                       empty,
    output logic                       full,
    output logic                       err_overflow
);
    localparam int AW = $clog2(NUM_TAGS);
    localparam int PW = AW + 1;

    logic [TAG_W-1:0] mem [NUM_TAGS];
    logic [PW-1:0]    head, tail, next_head, k, k_gnt, avail, n_free, n_acc;
    logic [PW-1:0]    off [FREE_W];
    logic [FREE_W-1:0] acc;
    logic             restore;

`ifdef FREE_LIST_CKPT_EN
    logic          ckpt_vld;
    logic [PW-1:0] ckpt_ptr;

    // Restore beats save; the snapshot holds the head after this cycle's grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ckpt_vld <= 1'b0;
            ckpt_ptr <= '0;
        end else if (restore) begin
            ckpt_vld <= 1'b0;
        end else if (ckpt_save) begin
            ckpt_vld <= 1'b1;
            ckpt_ptr <= head + k_gnt;
        end
    end

    assign restore   = ckpt_restore && ckpt_vld;
    assign next_head = restore ? ckpt_ptr : head + k_gnt;
`else
    logic unused_ckpt;

    assign unused_ckpt = ckpt_save | ckpt_restore;
    assign restore     = 1'b0;
    assign next_head   = head + k_gnt;
`endif

    assign count = tail - head;
    assign empty = count == '0;
    assign full  = count == PW'(NUM_TAGS);

    always_comb begin
        k = '0;
        for (int i = 0; i < ALLOC_W; i++)
            k = k + PW'(alloc_req[i]);
        alloc_gnt = (k != '0) && (k <= count) && !restore;
        k_gnt     = alloc_gnt ? k : '0;
        alloc_tag = '0;
        for (int i = 0; i < ALLOC_W; i++)
            if (alloc_gnt && alloc_req[i])
                alloc_tag[i*TAG_W +: TAG_W] = mem[head[AW-1:0] + AW'(i)];
        // Room left after this cycle's grant; lanes beyond it are dropped.
        avail  = PW'(NUM_TAGS) - count + k_gnt;
        n_free = '0;
        for (int j = 0; j < FREE_W; j++) begin
            off[j] = n_free;
            acc[j] = free_vld[j] && (n_free < avail);
            n_free = n_free + PW'(free_vld[j]);
        end
        n_acc = (n_free > avail) ? avail : n_free;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head         <= '0;
            tail         <= PW'(NUM_TAGS);
            err_overflow <= 1'b0;
        end else begin
            head         <= next_head;
            tail         <= tail + n_acc;
            err_overflow <= err_overflow | (n_free > avail);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_TAGS; i++)
                mem[i] <= TAG_W'(TAG_BASE + i);
        end else begin
            for (int j = 0; j < FREE_W; j++)
                if (acc[j])
                    mem[tail[AW-1:0] + off[j][AW-1:0]] <= free_tag[j*TAG_W +: TAG_W];
        end
    end
endmodule

// File: tb/tb_free_list_mp.sv
// tb_free_list_mp: randomized and directed checks of free_list_mp against a queue-based model.
module tb_free_list_mp;
    localparam int TAG_W    = 6;
    localparam int NUM_TAGS = 32;
    localparam int TAG_BASE = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  alloc_req = '0;
    logic [1:0]  free_vld = '0;
    logic [11:0] free_tag = '0;
    logic        ckpt_save = 1'b0;
    logic        ckpt_restore = 1'b0;
    logic        alloc_gnt;
    logic [11:0] alloc_tag;
    logic [5:0]  count;
    logic        empty, full, err_overflow;

    int   checks = 0;
    int   errors = 0;
    int   q[$];
    int   hist[$];
    bit   m_err, m_ck;
    logic exp_gnt, obs_gnt;
    logic [11:0] exp_tag, obs_tag;

    always #5 clk = ~clk;

    free_list_mp dut (
        .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
        .alloc_tag(alloc_tag), .free_vld(free_vld), .free_tag(free_tag),
        .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore), .count(count),
        .empty(empty), .full(full), .err_overflow(err_overflow)
    );

    task automatic model_reset();
        q.delete();
        hist.delete();
        for (int i = 0; i < NUM_TAGS; i++) q.push_back(TAG_BASE + i);
        m_err = 1'b0;
        m_ck  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        alloc_req = '0; free_vld = '0; free_tag = '0; ckpt_save = 1'b0; ckpt_restore = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock of stimulus; predicts grant/tags from the model, samples them, then advances the model.
    task automatic cycle(input logic [1:0] a, input logic [1:0] fv, input logic [11:0] ft,
                         input logic sv, input logic rs);
        int k;
        bit rest;
        int taken[$];
        @(negedge clk);
        alloc_req = a; free_vld = fv; free_tag = ft; ckpt_save = sv; ckpt_restore = rs;
        k = $countones(a);
`ifdef FREE_LIST_CKPT_EN
        rest = rs && m_ck;
`else
        rest = 1'b0;
`endif
        exp_gnt = (k > 0) && (k <= q.size()) && !rest;
        exp_tag = '0;
        if (exp_gnt)
            for (int i = 0; i < k; i++) exp_tag[i*TAG_W +: TAG_W] = TAG_W'(q[i]);
        #1;
        obs_gnt = alloc_gnt;
        obs_tag = alloc_tag;
        @(posedge clk);
        if (exp_gnt)
            for (int i = 0; i < k; i++) taken.push_back(q.pop_front());
        for (int j = 0; j < 2; j++)
            if (fv[j]) begin
                if (q.size() < NUM_TAGS) q.push_back(int'(ft[j*TAG_W +: TAG_W]));
                else m_err = 1'b1;
            end
        if (rest) begin
            for (int i = hist.size() - 1; i >= 0; i--) q.push_front(hist[i]);
            hist.delete();
            m_ck = 1'b0;
        end else begin
            foreach (taken[i]) hist.push_back(taken[i]);
            if (sv) begin
                hist.delete();
                m_ck = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        checks++; if (count !== 6'd32) begin errors++; $display("FAIL reset_count: got %0d want 32", count); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL reset_full: got %b want 1", full); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL reset_empty: got %b want 0", empty); end
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_overflow); end
        checks++; if (alloc_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0", alloc_gnt); end
        checks++; if (alloc_tag !== 12'd0) begin errors++; $display("FAIL reset_tag: got %h want 0", alloc_tag); end
        @(negedge clk);
        rst = 1'b0;
        cycle(2'b11, 2'b00, 12'd0, 1'b0, 1'b0);
        @(negedge clk);
        alloc_req = 2'b11; free_vld = 2'b11; free_tag = {6'd5, 6'd4};
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++; if (count !== 6'd32) begin errors++; $display("FAIL async_reset_count: got %0d want 32", count); end
        @(posedge clk);
        #1;
        checks++; if (count !== 6'd32 || err_overflow !== 1'b0) begin
            errors++; $display("FAIL reset_overrides: got count %0d err %b want 32 0", count, err_overflow); end
        @(negedge clk);
        rst = 1'b0; alloc_req = '0; free_vld = '0; free_tag = '0;
    endtask

    task automatic test_alloc_pair();
        do_reset();
        cycle(2'b11, 2'b00, 12'd0, 1'b0, 1'b0);
        checks++; if (obs_gnt !== 1'b1) begin errors++; $display("FAIL pair_gnt: got %b want 1", obs_gnt); end
        checks++; if (obs_tag !== {6'd33, 6'd32}) begin errors++; $display("FAIL pair_tags: got %h want %h", obs_tag, {6'd33, 6'd32}); end
        checks++; if (count !== 6'd30 || full !== 1'b0) begin
            errors++; $display("FAIL pair_count: got %0d full %b want 30 0", count, full); end
    endtask

    task automatic test_same_cycle();
        cycle(2'b01, 2'b10, {6'd40, 6'd0}, 1'b0, 1'b0);
        checks++; if (obs_gnt !== 1'b1 || obs_tag !== {6'd0, 6'd34}) begin
            errors++; $display("FAIL same_cycle_grant: got %b %h want 1 %h", obs_gnt, obs_tag, {6'd0, 6'd34}); end
        checks++; if (count !== 6'd30) begin errors++; $display("FAIL same_cycle_count: got %0d want 30", count); end
        while (q.size() >= 2) begin
            cycle(2'b11, 2'b00, 12'd0, 1'b0, 1'b0);
            checks++; if (obs_gnt !== exp_gnt || obs_tag !== exp_tag) begin
                errors++; $display("FAIL drain_tags: got %b %h want %b %h", obs_gnt, obs_tag, exp_gnt, exp_tag); end
        end
        checks++; if (obs_tag !== {6'd40, 6'd63}) begin
            errors++; $display("FAIL freed_at_tail: got %h want %h", obs_tag, {6'd40, 6'd63}); end
    endtask

    task automatic test_drain_boundary();
        do_reset();
        for (int i = 0; i < 15; i++) cycle(2'b11, 2'b00, 12'd0, 1'b0, 1'b0);
        cycle(2'b01, 2'b00, 12'd0, 1'b0, 1'b0);
        checks++; if (count !== 6'd1) begin errors++; $display("FAIL drain_count: got %0d want 1", count); end
        cycle(2'b11, 2'b00, 12'd0, 1'b0, 1'b0);
        checks++; if (obs_gnt !== 1'b0 || obs_tag !== 12'd0 || count !== 6'd1) begin
            errors++; $display("FAIL short_deny: got gnt %b tag %h count %0d want 0 0 1", obs_gnt, obs_tag, count); end
        cycle(2'b01, 2'b00, 12'd0, 1'b0, 1'b0);
        checks++; if (obs_gnt !== 1'b1 || obs_tag !== {6'd0, 6'd63}) begin
            errors++; $display("FAIL last_tag: got %b %h want 1 %h", obs_gnt, obs_tag, {6'd0, 6'd63}); end
        checks++; if (empty !== 1'b1 || count !== 6'd0) begin
            errors++; $display("FAIL empty: got %b count %0d want 1 0", empty, count); end
        cycle(2'b01, 2'b00, 12'd0, 1'b0, 1'b0);
        checks++; if (obs_gnt !== 1'b0) begin errors++; $display("FAIL empty_deny: got %b want 0", obs_gnt); end
    endtask

    task automatic test_overflow();
        do_reset();
        cycle(2'b00, 2'b11, {6'd2, 6'd1}, 1'b0, 1'b0);
        checks++; if (err_overflow !== 1'b1 || count !== 6'd32) begin
            errors++; $display("FAIL overflow_full: got err %b count %0d want 1 32", err_overflow, count); end
        cycle(2'b00, 2'b00, 12'd0, 1'b0, 1'b0);
        checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %b want 1", err_overflow); end
        do_reset();
        cycle(2'b01, 2'b00, 12'd0, 1'b0, 1'b0);
        cycle(2'b00, 2'b11, {6'd9, 6'd8}, 1'b0, 1'b0);
        checks++; if (err_overflow !== 1'b1 || count !== 6'd32) begin
            errors++; $display("FAIL partial_drop: got err %b count %0d want 1 32", err_overflow, count); end
        for (int i = 0; i < 16; i++) begin
            cycle(2'b11, 2'b00, 12'd0, 1'b0, 1'b0);
            checks++; if (obs_tag !== exp_tag) begin
                errors++; $display("FAIL partial_drop_order: got %h want %h", obs_tag, exp_tag); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cycle(2'b11, 2'b11, {6'(2*i+1), 6'(2*i)}, 1'b0, 1'b0);
            checks++; if (obs_gnt !== exp_gnt || obs_tag !== exp_tag) begin
                errors++; $display("FAIL wrap_tags %0d: got %b %h want %b %h", i, obs_gnt, obs_tag, exp_gnt, exp_tag); end
            checks++; if (count !== 6'd32 || err_overflow !== 1'b0) begin
                errors++; $display("FAIL wrap_count %0d: got %0d err %b want 32 0", i, count, err_overflow); end
            if (i == 16) begin
                checks++; if (obs_tag !== {6'd1, 6'd0}) begin
                    errors++; $display("FAIL wrap_fifo: got %h want %h", obs_tag, {6'd1, 6'd0}); end
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] a, fv;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bit alloc_heavy;
            alloc_heavy = ((c / 60) % 2) == 0;
            case ($urandom_range(0, 3))
                0:       a = 2'b00;
                1:       a = 2'b01;
                default: a = alloc_heavy ? 2'b11 : 2'b01;
            endcase
            fv = 2'($urandom);
            if (alloc_heavy && $urandom_range(0, 1) == 1) fv = 2'b00;
            cycle(a, fv, 12'($urandom), 1'b0, 1'b0);
            checks++; if (obs_gnt !== exp_gnt || obs_tag !== exp_tag) begin
                errors++; $display("FAIL rand_alloc %0d: got %b %h want %b %h", c, obs_gnt, obs_tag, exp_gnt, exp_tag); end
            checks++; if (count !== 6'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == NUM_TAGS)) begin
                errors++; $display("FAIL rand_count %0d: got %0d e%b f%b want %0d", c, count, empty, full, q.size()); end
            checks++; if (err_overflow !== m_err) begin
                errors++; $display("FAIL rand_err %0d: got %b want %b", c, err_overflow, m_err); end
        end
    endtask

`ifdef FREE_LIST_CKPT_EN
    task automatic test_ckpt();
        do_reset();
        cycle(2'b01, 2'b00, 12'd0, 1'b1, 1'b0);
        checks++; if (obs_tag !== {6'd0, 6'd32}) begin errors++; $display("FAIL ckpt_save_tag: got %h want %h", obs_tag, {6'd0, 6'd32}); end
        cycle(2'b11, 2'b00, 12'd0, 1'b0, 1'b0);
        cycle(2'b01, 2'b00, 12'd0, 1'b0, 1'b1);
        checks++; if (obs_gnt !== 1'b0 || count !== 6'd31) begin
            errors++; $display("FAIL ckpt_restore: got gnt %b count %0d want 0 31", obs_gnt, count); end
        cycle(2'b01, 2'b00, 12'd0, 1'b0, 1'b0);
        checks++; if (obs_gnt !== 1'b1 || obs_tag !== {6'd0, 6'd33}) begin
            errors++; $display("FAIL ckpt_replay: got %b %h want 1 %h", obs_gnt, obs_tag, {6'd0, 6'd33}); end
        cycle(2'b01, 2'b00, 12'd0, 1'b0, 1'b1);
        checks++; if (obs_gnt !== 1'b1 || obs_tag !== {6'd0, 6'd34} || count !== 6'd29) begin
            errors++; $display("FAIL ckpt_invalid: got %b %h count %0d want 1 %h 29", obs_gnt, obs_tag, count, {6'd0, 6'd34}); end
    endtask
`endif

    initial begin
        test_reset();
        test_alloc_pair();
        test_same_cycle();
        test_drain_boundary();
        test_overflow();
        test_wrap();
`ifdef FREE_LIST_CKPT_EN
        test_ckpt();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
